fu_result_buffer: RTL and testbench

//  Per-functional-unit completion queue between an execution unit (ALU/MUL/MEM) and the cdb arbiter.
//  The cdb grants one unit per cycle, so losing units must hold finished results instead of dropping them.

---
 rtl/fu_result_buffer_pkg.sv | 21 ++
 rtl/fu_result_buffer_if.sv | 35 +++
 rtl/fu_result_buffer_chk.sv | 27 ++
 rtl/fu_result_buffer.sv | 100 ++++++++++
 tb/tb_fu_result_buffer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fu_result_buffer_pkg.sv
// Shared types for the functional-unit result buffer: the CDB packet and
// the width constants it is built from.
package fu_result_buffer_pkg;

  localparam int XLEN    = 32;
  localparam int PRF_LEN = 6;
  localparam int ROB_LEN = 5;

  typedef struct packed {
    logic [XLEN-1:0]    value;
    logic [PRF_LEN-1:0] prf_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic [XLEN-1:0]    PC;
  } CDB_PACKET;

  // Ring pointers wrap for free only when the depth is a power of two.
  function automatic logic is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fu_result_buffer_if.sv
// Bundle of execution-unit push, cdb pop/squash and head-entry signals.
// The buffer takes the slave view; the unit/cdb side drives through master.
interface fu_result_buffer_if
  import fu_result_buffer_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int PTR_LEN = $clog2(DEPTH);

  logic               fu_valid;
  logic [XLEN-1:0]    fu_value;
  logic [PRF_LEN-1:0] fu_prf_idx;
  logic [ROB_LEN-1:0] fu_rob_idx;
  logic [XLEN-1:0]    fu_PC;
  logic               fu_ready;
  logic               cdb_grant;
  logic               squash;
  logic               out_valid;
  logic [XLEN-1:0]    out_value;
  logic [PRF_LEN-1:0] out_prf_idx;
  logic [ROB_LEN-1:0] out_rob_idx;
  logic [XLEN-1:0]    out_PC;
  logic [PTR_LEN:0]   count;

  modport slave (
    input  fu_valid, fu_value, fu_prf_idx, fu_rob_idx, fu_PC, cdb_grant, squash,
    output fu_ready, out_valid, out_value, out_prf_idx, out_rob_idx, out_PC, count
  );

  modport master (
    output fu_valid, fu_value, fu_prf_idx, fu_rob_idx, fu_PC, cdb_grant, squash,
    input  fu_ready, out_valid, out_value, out_prf_idx, out_rob_idx, out_PC, count
  );

endinterface

// File: rtl/fu_result_buffer_chk.sv
// Protocol and occupancy checks for fu_result_buffer; no synthesizable logic.
module fu_result_buffer_chk #(
  parameter int DEPTH = 4
) (
  input logic                     clock_i,
  input logic                     reset_i,
  input logic                     fu_valid_i,
  input logic                     out_valid_i,
  input logic [$clog2(DEPTH):0]   count_i
);
  localparam int PTR_LEN = $clog2(DEPTH);
  localparam logic [PTR_LEN:0] DEPTH_C = (PTR_LEN+1)'(DEPTH);

  a_count_range: assert property (@(posedge clock_i) disable iff (reset_i)
    count_i <= DEPTH_C)
    else $error("fu_result_buffer: count above depth");

  a_valid_count: assert property (@(posedge clock_i) disable iff (reset_i)
    out_valid_i == (count_i != {(PTR_LEN+1){1'b0}}))
    else $error("fu_result_buffer: out_valid disagrees with count");

  // A unit presenting a result while the buffer is full has ignored fu_ready.
  a_no_push_full: assert property (@(posedge clock_i) disable iff (reset_i)
    !(fu_valid_i && (count_i == DEPTH_C)))
    else $error("fu_result_buffer: push while full, packet dropped");

endmodule

// File: rtl/fu_result_buffer.sv
// In-order completion queue between one execution unit and the cdb arbiter:
// holds finished results until granted, flushed on branch mispredict.
module fu_result_buffer
  import fu_result_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clock,
  input logic               reset,
  fu_result_buffer_if.slave bus
);
  localparam int PTR_LEN = $clog2(DEPTH);
  localparam logic [PTR_LEN:0]   DEPTH_C  = (PTR_LEN+1)'(DEPTH);
  localparam logic [PTR_LEN-1:0] PTR_ONE  = {{(PTR_LEN-1){1'b0}}, 1'b1};
  localparam logic [PTR_LEN:0]   CNT_ONE  = {{PTR_LEN{1'b0}}, 1'b1};

  CDB_PACKET          mem_q [DEPTH];
  logic [PTR_LEN-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_LEN:0]   count_q, count_d;
  logic               push_s, pop_s;
  CDB_PACKET          in_pkt_s, head_pkt_s;

  // Push/pop qualification and next-state pointers; squash overrides both.
  always_comb begin
    in_pkt_s.value   = bus.fu_value;
    in_pkt_s.prf_idx = bus.fu_prf_idx;
    in_pkt_s.rob_idx = bus.fu_rob_idx;
    in_pkt_s.PC      = bus.fu_PC;
    push_s  = bus.fu_valid && (count_q < DEPTH_C) && !bus.squash;
    pop_s   = bus.cdb_grant && (count_q != {(PTR_LEN+1){1'b0}}) && !bus.squash;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.squash) begin
      head_d  = {PTR_LEN{1'b0}};
      tail_d  = {PTR_LEN{1'b0}};
      count_d = {(PTR_LEN+1){1'b0}};
    end else begin
      if (push_s) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= {PTR_LEN{1'b0}};
      tail_q  <= {PTR_LEN{1'b0}};
      count_q <= {(PTR_LEN+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_s) begin
        mem_q[tail_q] <= in_pkt_s;
      end
    end
  end

  // Head presentation; data is forced to zero when the queue is empty.
  always_comb begin
    bus.out_valid = (count_q != {(PTR_LEN+1){1'b0}});
    bus.fu_ready  = (count_q < DEPTH_C);
    bus.count     = count_q;
    if (bus.out_valid) begin
      head_pkt_s = mem_q[head_q];
    end else begin
      head_pkt_s = '0;
    end
    bus.out_value   = head_pkt_s.value;
    bus.out_prf_idx = head_pkt_s.prf_idx;
    bus.out_rob_idx = head_pkt_s.rob_idx;
    bus.out_PC      = head_pkt_s.PC;
  end

  fu_result_buffer_chk #(.DEPTH(DEPTH)) u_chk (
    .clock_i    (clock),
    .reset_i    (reset),
    .fu_valid_i (bus.fu_valid),
    .out_valid_i(bus.out_valid),
    .count_i    (count_q)
  );

endmodule

// File: tb/tb_fu_result_buffer.sv
// Directed and model-checked tests for fu_result_buffer (DEPTH=4).
module tb_fu_result_buffer;
  import fu_result_buffer_pkg::*;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_mis;

  fu_result_buffer_if #(.DEPTH(4)) bus ();

  fu_result_buffer #(.DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] val, input logic [5:0] prf,
                       input logic [4:0] rob, input logic [31:0] pc,
                       input logic g, input logic sq);
    bus.fu_valid   = v;
    bus.fu_value   = val;
    bus.fu_prf_idx = prf;
    bus.fu_rob_idx = rob;
    bus.fu_PC      = pc;
    bus.cdb_grant  = g;
    bus.squash     = sq;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 6'd0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    n_cmp++; if (bus.fu_ready !== 1'b1) begin n_mis++; $display("FAIL reset_fu_ready got %0b exp 1", bus.fu_ready); end
    n_cmp++; if (bus.count !== 3'd0) begin n_mis++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.out_value !== 32'h0) begin n_mis++; $display("FAIL reset_out_value got %h exp 0", bus.out_value); end
  endtask

  task automatic test_single_push();
    drive(1'b1, 32'h11, 6'd5, 5'd3, 32'h100, 1'b0, 1'b0);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL single_no_bypass got %0b exp 0", bus.out_valid); end
    tick();
    idle();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_mis++; $display("FAIL single_valid got %0b exp 1", bus.out_valid); end
    n_cmp++; if (bus.out_value !== 32'h11) begin n_mis++; $display("FAIL single_value got %h exp 11", bus.out_value); end
    n_cmp++; if (bus.out_prf_idx !== 6'd5) begin n_mis++; $display("FAIL single_prf got %0d exp 5", bus.out_prf_idx); end
    n_cmp++; if (bus.out_rob_idx !== 5'd3) begin n_mis++; $display("FAIL single_rob got %0d exp 3", bus.out_rob_idx); end
    n_cmp++; if (bus.out_PC !== 32'h100) begin n_mis++; $display("FAIL single_pc got %h exp 100", bus.out_PC); end
    n_cmp++; if (bus.count !== 3'd1) begin n_mis++; $display("FAIL single_count got %0d exp 1", bus.count); end
    bus.cdb_grant = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL single_pop_valid got %0b exp 0", bus.out_valid); end
    n_cmp++; if (bus.count !== 3'd0) begin n_mis++; $display("FAIL single_pop_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.out_value !== 32'h0) begin n_mis++; $display("FAIL single_pop_zero got %h exp 0", bus.out_value); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 6'(i), 5'(i), 32'h200 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    idle();
    n_cmp++; if (bus.count !== 3'd4) begin n_mis++; $display("FAIL fill_count got %0d exp 4", bus.count); end
    n_cmp++; if (bus.fu_ready !== 1'b0) begin n_mis++; $display("FAIL fill_ready got %0b exp 0", bus.fu_ready); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (bus.out_value !== 32'(i)) begin n_mis++; $display("FAIL fill_order got %0d exp %0d", bus.out_value, i); end
      bus.cdb_grant = 1'b1;
      #1;
      n_cmp++; if (i == 1 && bus.fu_ready !== 1'b0) begin n_mis++; $display("FAIL fill_ready_comb got %0b exp 0", bus.fu_ready); end
      tick();
      if (i == 1) begin
        n_cmp++; if (bus.fu_ready !== 1'b1) begin n_mis++; $display("FAIL fill_ready_after_pop got %0b exp 1", bus.fu_ready); end
        n_cmp++; if (bus.count !== 3'd3) begin n_mis++; $display("FAIL fill_count_after_pop got %0d exp 3", bus.count); end
      end
    end
    idle();
    n_cmp++; if (bus.count !== 3'd0) begin n_mis++; $display("FAIL fill_drain_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_push_pop();
    drive(1'b1, 32'd20, 6'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd21, 6'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd22, 6'd0, 5'd0, 32'h0, 1'b1, 1'b0);
    tick();
    n_cmp++; if (bus.count !== 3'd2) begin n_mis++; $display("FAIL pp_count got %0d exp 2", bus.count); end
    n_cmp++; if (bus.out_value !== 32'd21) begin n_mis++; $display("FAIL pp_head got %0d exp 21", bus.out_value); end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'd23 + 32'(k), 6'd0, 5'd0, 32'h0, 1'b1, 1'b0);
      tick();
      n_cmp++; if (bus.count !== 3'd2) begin n_mis++; $display("FAIL wrap_count k=%0d got %0d exp 2", k, bus.count); end
      n_cmp++; if (bus.out_value !== 32'd22 + 32'(k)) begin n_mis++; $display("FAIL wrap_head k=%0d got %0d exp %0d", k, bus.out_value, 22 + k); end
    end
    idle();
    n_cmp++; if (bus.out_value !== 32'd31) begin n_mis++; $display("FAIL wrap_tail0 got %0d exp 31", bus.out_value); end
    bus.cdb_grant = 1'b1;
    tick();
    n_cmp++; if (bus.out_value !== 32'd32) begin n_mis++; $display("FAIL wrap_tail1 got %0d exp 32", bus.out_value); end
    tick();
    idle();
    n_cmp++; if (bus.count !== 3'd0) begin n_mis++; $display("FAIL wrap_drain got %0d exp 0", bus.count); end
  endtask

  task automatic test_squash();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd40 + 32'(i), 6'd0, 5'd0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'd43, 6'd1, 5'd1, 32'h0, 1'b1, 1'b1);
    tick();
    idle();
    n_cmp++; if (bus.count !== 3'd0) begin n_mis++; $display("FAIL squash_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL squash_valid got %0b exp 0", bus.out_valid); end
    n_cmp++; if (bus.out_value !== 32'h0) begin n_mis++; $display("FAIL squash_value got %0d exp 0", bus.out_value); end
    drive(1'b1, 32'd44, 6'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    n_cmp++; if (bus.out_value !== 32'd44) begin n_mis++; $display("FAIL squash_after got %0d exp 44", bus.out_value); end
    n_cmp++; if (bus.count !== 3'd1) begin n_mis++; $display("FAIL squash_after_count got %0d exp 1", bus.count); end
    // Reset in the middle of traffic behaves like a squash.
    drive(1'b1, 32'd45, 6'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    n_cmp++; if (bus.count !== 3'd0) begin n_mis++; $display("FAIL midreset_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.out_value !== 32'h0) begin n_mis++; $display("FAIL midreset_value got %0d exp 0", bus.out_value); end
  endtask

  task automatic test_grant_empty();
    bus.cdb_grant = 1'b1;
    tick();
    tick();
    idle();
    n_cmp++; if (bus.count !== 3'd0) begin n_mis++; $display("FAIL gempty_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL gempty_valid got %0b exp 0", bus.out_valid); end
    drive(1'b1, 32'd50, 6'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    n_cmp++; if (bus.out_value !== 32'd50) begin n_mis++; $display("FAIL gempty_push got %0d exp 50", bus.out_value); end
    n_cmp++; if (bus.count !== 3'd1) begin n_mis++; $display("FAIL gempty_push_count got %0d exp 1", bus.count); end
    bus.cdb_grant = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [36:0] q[$];
    logic [36:0] exp_head;
    logic        v, g, sq;
    logic [31:0] val;
    logic [4:0]  rob;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      exp_head = (q.size() != 0) ? q[0] : 37'h0;
      n_cmp++;
      if (bus.count !== 3'(q.size()) || bus.out_valid !== (q.size() != 0) ||
          {bus.out_rob_idx, bus.out_value} !== exp_head) begin
        n_mis++;
        $display("FAIL random c=%0d got cnt=%0d v=%0b %h exp cnt=%0d %h", c, bus.count,
                 bus.out_valid, {bus.out_rob_idx, bus.out_value}, q.size(), exp_head);
      end
      v   = ($urandom_range(0, 99) < 60) && (q.size() < 4);
      g   = ($urandom_range(0, 99) < 50);
      sq  = ($urandom_range(0, 99) < 3);
      val = $urandom;
      rob = 5'($urandom_range(0, 31));
      drive(v, val, 6'd0, rob, 32'h0, g, sq);
      if (sq) begin
        q.delete();
      end else begin
        if (g && q.size() != 0) void'(q.pop_front());
        if (v) q.push_back({rob, val});
      end
      tick();
    end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b1;
    idle();
    test_reset();
    test_single_push();
    test_fill();
    test_push_pop();
    test_squash();
    test_grant_empty();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
